// File: rtl/dll_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// dll_tx_scheduler_if
// Bundles the requester handshakes (ACK/NAK DLLP, FC DLLP, TLP stream), the
// DLCMSM state and the DLL->PIPE output lane of the DLL TX scheduler.
//   master : requester / lane-consumer side (drives valids, payloads, state)
//   slave  : scheduler side (drives readys, output beat, status pulses)
// Signals:
//   dlcm_state_i      2b  0=INACTIVE 1=INIT1 2=INIT2 3=ACTIVE
//   ack_valid_i/ack_dllp_i/ack_ready_o   ACK/NAK DLLP handshake, 64b payload
//   fc_valid_i/fc_dllp_i/fc_ready_o      FC DLLP handshake, 64b payload
//   tlp_valid_i/tlp_sop_i/tlp_eop_i/tlp_data_i/tlp_ready_o  TLP beat handshake
//   dll2pipe_data_o/dll2pipe_valid_o/dll2pipe_dllp_o        registered lane beat
//   tlp_abort_o       TLP cut off by link leaving ACTIVE (1-cycle pulse)
//   proto_err_o       stray non-sop TLP beat flushed (1-cycle pulse)
// ---------------------------------------------------------------------------
interface dll_tx_scheduler_if #(
   parameter int unsigned PIPE_DATA_WIDTH = 256
);
   localparam int unsigned DLLP_W = 64;

   logic [1:0]                 dlcm_state_i;
   logic                       ack_valid_i;
   logic [DLLP_W-1:0]          ack_dllp_i;
   logic                       ack_ready_o;
   logic                       fc_valid_i;
   logic [DLLP_W-1:0]          fc_dllp_i;
   logic                       fc_ready_o;
   logic                       tlp_valid_i;
   logic                       tlp_sop_i;
   logic                       tlp_eop_i;
   logic [PIPE_DATA_WIDTH-1:0] tlp_data_i;
   logic                       tlp_ready_o;
   logic [PIPE_DATA_WIDTH-1:0] dll2pipe_data_o;
   logic                       dll2pipe_valid_o;
   logic                       dll2pipe_dllp_o;
   logic                       tlp_abort_o;
   logic                       proto_err_o;

   modport master (
      output dlcm_state_i,
      output ack_valid_i, ack_dllp_i,
      input  ack_ready_o,
      output fc_valid_i, fc_dllp_i,
      input  fc_ready_o,
      output tlp_valid_i, tlp_sop_i, tlp_eop_i, tlp_data_i,
      input  tlp_ready_o,
      input  dll2pipe_data_o, dll2pipe_valid_o, dll2pipe_dllp_o,
      input  tlp_abort_o, proto_err_o
   );

   modport slave (
      input  dlcm_state_i,
      input  ack_valid_i, ack_dllp_i,
      output ack_ready_o,
      input  fc_valid_i, fc_dllp_i,
      output fc_ready_o,
      input  tlp_valid_i, tlp_sop_i, tlp_eop_i, tlp_data_i,
      output tlp_ready_o,
      output dll2pipe_data_o, dll2pipe_valid_o, dll2pipe_dllp_o,
      output tlp_abort_o, proto_err_o
   );
endinterface

// File: rtl/dll_tx_scheduler.sv
// ---------------------------------------------------------------------------
// dll_tx_scheduler
// Link-side TX scheduler of the DLL: arbitrates the single DLL->PIPE lane
// between ACK/NAK DLLPs, FC DLLPs and the TLP stream, gated by DLCMSM state.
// A TLP is never split by a DLLP; TLP starvation under DLLP pressure is
// bounded by MAX_DLLP_STREAK consecutive DLLP grants.
// Ports:
//   sclk  clock
//   srst  synchronous reset, active-high
//   bus   dll_tx_scheduler_if.slave (handshakes, DLCM state, output lane)
// Readys are combinational; the output lane and status pulses are registered.
// ---------------------------------------------------------------------------
module dll_tx_scheduler #(
   parameter int unsigned PIPE_DATA_WIDTH = 256,
   parameter int unsigned MAX_DLLP_STREAK = 4
) (
   input logic               sclk,
   input logic               srst,
   dll_tx_scheduler_if.slave bus
);
   localparam int unsigned STREAK_W = 4;
   localparam logic [STREAK_W-1:0] STREAK_SAT = '1;
   localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(MAX_DLLP_STREAK);

   localparam logic [1:0] DLCM_INIT1  = 2'd1;
   localparam logic [1:0] DLCM_INIT2  = 2'd2;
   localparam logic [1:0] DLCM_ACTIVE = 2'd3;

   typedef enum logic {
      ST_IDLE,
      ST_TLP_BUSY
   } state_e;

   typedef enum logic [2:0] {
      G_NONE,
      G_ACK,
      G_FC,
      G_TLP,
      G_DROP
   } grant_e;

   state_e                     state_q, state_d;
   logic [STREAK_W-1:0]        streak_q, streak_d;
   grant_e                     grant_c;
   logic                       sop_wait_c;
   logic                       abort_c;

   logic [PIPE_DATA_WIDTH-1:0] data_q;
   logic                       valid_q;
   logic                       dllp_q;
   logic                       abort_q;
   logic                       perr_q;

   // Grant selection, next state and streak tracking
   always_comb begin
      state_d    = state_q;
      streak_d   = streak_q;
      grant_c    = G_NONE;
      abort_c    = 1'b0;
      sop_wait_c = bus.tlp_valid_i & bus.tlp_sop_i;

      case (state_q)
         ST_IDLE: begin
            case (bus.dlcm_state_i)
               DLCM_ACTIVE: begin
                  // Starved TLP start overrides both DLLP sources
                  if (sop_wait_c && (streak_q >= STREAK_LIM)) grant_c = G_TLP;
                  else if (bus.ack_valid_i)                   grant_c = G_ACK;
                  else if (bus.fc_valid_i)                    grant_c = G_FC;
                  else if (sop_wait_c)                        grant_c = G_TLP;
                  else if (bus.tlp_valid_i)                   grant_c = G_DROP;
               end
               DLCM_INIT1, DLCM_INIT2: begin
                  if (bus.fc_valid_i) grant_c = G_FC;
               end
               default: ;
            endcase
            if ((grant_c == G_TLP) && !bus.tlp_eop_i) state_d = ST_TLP_BUSY;
         end
         ST_TLP_BUSY: begin
            // Link dropped out of ACTIVE: abandon the TLP, no beat accepted
            if (bus.dlcm_state_i != DLCM_ACTIVE) begin
               state_d = ST_IDLE;
               abort_c = 1'b1;
            end else if (bus.tlp_valid_i) begin
               grant_c = G_TLP;
               if (bus.tlp_eop_i) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (((grant_c == G_ACK) || (grant_c == G_FC)) && sop_wait_c) begin
         if (streak_q != STREAK_SAT) streak_d = streak_q + 4'd1;
      end else if (!sop_wait_c || (grant_c == G_TLP)) begin
         streak_d = '0;
      end
   end

   assign bus.ack_ready_o = (grant_c == G_ACK);
   assign bus.fc_ready_o  = (grant_c == G_FC);
   assign bus.tlp_ready_o = (grant_c == G_TLP) || (grant_c == G_DROP);

   // State, streak and registered output lane
   always_ff @(posedge sclk) begin
      if (srst) begin
         state_q  <= ST_IDLE;
         streak_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         dllp_q   <= 1'b0;
         abort_q  <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         valid_q  <= (grant_c == G_ACK) || (grant_c == G_FC) || (grant_c == G_TLP);
         dllp_q   <= (grant_c == G_ACK) || (grant_c == G_FC);
         abort_q  <= abort_c;
         perr_q   <= (grant_c == G_DROP);
         case (grant_c)
            G_ACK:   data_q <= PIPE_DATA_WIDTH'(bus.ack_dllp_i);
            G_FC:    data_q <= PIPE_DATA_WIDTH'(bus.fc_dllp_i);
            G_TLP:   data_q <= bus.tlp_data_i;
            default: data_q <= '0;
         endcase
      end
   end

   assign bus.dll2pipe_data_o  = data_q;
   assign bus.dll2pipe_valid_o = valid_q;
   assign bus.dll2pipe_dllp_o  = dllp_q;
   assign bus.tlp_abort_o      = abort_q;
   assign bus.proto_err_o      = perr_q;

endmodule
